// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default PROT and the
// command-master state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    localparam logic [2:0] ProtDefault = 3'b000;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrReq  = 3'd1,
        StWrResp = 3'd2,
        StRdReq  = 3'd3,
        StRdData = 3'd4,
        StRsp    = 3'd5
    } mst_state_e;

endpackage

// File: rtl/axi_lite_wdog.sv
// Saturating watchdog counter with synchronous clear and count enable.
// A Limit of 0 disables expiry entirely.
module axi_lite_wdog #(
    parameter int unsigned Limit = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (Limit < 2) ? 1 : $clog2(Limit + 1);
    localparam logic [CntW-1:0] LimitC = CntW'(Limit);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LimitC)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (Limit != 0) && (cnt_q == LimitC);

endmodule

// File: rtl/axi_lite_master_cmd.sv
// AXI4-Lite master that runs one read or write per command and returns the
// outcome on a response stream, with a watchdog flag for slow slaves.
module axi_lite_master_cmd
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_TIMEOUT_CYCLES   = 256,
    parameter logic [2:0]  C_M_AXI_PROT       = ProtDefault
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            CMD_VALID,
    output logic                            CMD_READY,
    input  logic                            CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
    output logic                            RSP_VALID,
    input  logic                            RSP_READY,
    output logic                            RSP_WRITE,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]                      RSP_RESP,
    output logic                            TIMEOUT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;

    // Reset asserts asynchronously but releases two clocks after the pin rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    mst_state_e                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]              wstrb_q, wstrb_d;
    logic                          write_q, write_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                    resp_q, resp_d;

    logic cmd_hs, rsp_hs, aw_hs, w_hs, busy;

    assign cmd_hs = CMD_VALID && CMD_READY;
    assign rsp_hs = RSP_VALID && RSP_READY;
    assign aw_hs  = awvalid_q && M_AXI_AWREADY;
    assign w_hs   = wvalid_q && M_AXI_WREADY;
    assign busy   = (state_q == StWrReq) || (state_q == StWrResp) ||
                    (state_q == StRdReq) || (state_q == StRdData);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        unique case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    addr_d    = CMD_ADDR;
                    wdata_d   = CMD_WDATA;
                    wstrb_d   = CMD_WSTRB;
                    write_d   = CMD_WRITE;
                    rdata_d   = '0;
                    resp_d    = RespOkay;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (CMD_WRITE) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrReq;
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end
            StWrReq: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    state_d = StRsp;
                end
            end
            StRdReq: begin
                if (M_AXI_ARREADY) begin
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (RSP_READY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    axi_lite_wdog #(
        .Limit(C_TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (M_AXI_ACLK),
        .rst_ni   (rst_n),
        .clr_i    (cmd_hs || rsp_hs),
        .en_i     (busy),
        .expired_o(TIMEOUT)
    );

    // All outputs come from registered state only; no READY-to-VALID paths.
    assign CMD_READY     = rst_n && (state_q == StIdle);
    assign RSP_VALID     = (state_q == StRsp);
    assign RSP_WRITE     = write_q;
    assign RSP_RDATA     = rdata_q;
    assign RSP_RESP      = resp_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = C_M_AXI_PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == StWrResp);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = C_M_AXI_PROT;
    assign M_AXI_ARVALID = (state_q == StRdReq);
    assign M_AXI_RREADY  = (state_q == StRdData);

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed bench for axi_lite_master_cmd: cycle-exact handshakes, stalls,
// watchdog expiry and mid-transaction reset.
module tb_axi_lite_master_cmd;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write, timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;
    int aw_beats = 0;
    int w_beats  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (awvalid && awready) aw_beats <= aw_beats + 1;
        if (wvalid && wready)   w_beats  <= w_beats + 1;
    end

    axi_lite_master_cmd #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_TIMEOUT_CYCLES  (8),
        .C_M_AXI_PROT      (3'b000)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .CMD_VALID    (cmd_valid),
        .CMD_READY    (cmd_ready),
        .CMD_WRITE    (cmd_write),
        .CMD_ADDR     (cmd_addr),
        .CMD_WDATA    (cmd_wdata),
        .CMD_WSTRB    (cmd_wstrb),
        .RSP_VALID    (rsp_valid),
        .RSP_READY    (rsp_ready),
        .RSP_WRITE    (rsp_write),
        .RSP_RDATA    (rsp_rdata),
        .RSP_RESP     (rsp_resp),
        .TIMEOUT      (timeout),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    initial begin
        int aw0, w0;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;

        // Reset state
        repeat (2) step();
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_awaddr", awaddr, 0);
        check_eq("rst_wdata", wdata, 0);
        rst_n = 1'b1;
        repeat (3) step();
        check_eq("post_rst_cmd_ready", cmd_ready, 1);
        check_eq("awprot", awprot, 0);
        check_eq("arprot", arprot, 0);

        // Zero-wait write
        issue(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF);
        awready = 1; wready = 1;
        step();
        cmd_valid = 0;
        check_eq("w1_awvalid", awvalid, 1);
        check_eq("w1_wvalid", wvalid, 1);
        check_eq("w1_awaddr", awaddr, 32'h10);
        check_eq("w1_wdata", wdata, 32'hA5A5_5A5A);
        check_eq("w1_wstrb", wstrb, 4'hF);
        check_eq("w1_cmd_ready", cmd_ready, 0);
        check_eq("w1_bready_early", bready, 0);
        step();
        awready = 0; wready = 0;
        check_eq("w1_awvalid_drop", awvalid, 0);
        check_eq("w1_wvalid_drop", wvalid, 0);
        check_eq("w1_bready", bready, 1);
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0;
        check_eq("w1_rsp_valid", rsp_valid, 1);
        check_eq("w1_rsp_write", rsp_write, 1);
        check_eq("w1_rsp_resp", rsp_resp, 2'b00);
        check_eq("w1_rsp_rdata", rsp_rdata, 0);
        check_eq("w1_bready_off", bready, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        check_eq("w1_rsp_done", rsp_valid, 0);
        check_eq("w1_cmd_ready", cmd_ready, 1);

        // Write with WREADY lagging AWREADY by 3 cycles
        aw0 = aw_beats; w0 = w_beats;
        issue(1'b1, 32'h44, 32'h1234_5678, 4'h3);
        awready = 1;
        step();
        cmd_valid = 0;
        check_eq("w2_awvalid", awvalid, 1);
        check_eq("w2_wvalid", wvalid, 1);
        step();
        awready = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("w2_awvalid_low%0d", i), awvalid, 0);
            check_eq($sformatf("w2_wvalid_held%0d", i), wvalid, 1);
            check_eq($sformatf("w2_wdata_stable%0d", i), wdata, 32'h1234_5678);
            check_eq($sformatf("w2_wstrb_stable%0d", i), wstrb, 4'h3);
            check_eq($sformatf("w2_bready_low%0d", i), bready, 0);
            if (i == 2) wready = 1;
            step();
        end
        wready = 0;
        check_eq("w2_wvalid_drop", wvalid, 0);
        check_eq("w2_bready", bready, 1);
        bvalid = 1; bresp = 2'b01;
        step();
        bvalid = 0;
        check_eq("w2_rsp_valid", rsp_valid, 1);
        check_eq("w2_rsp_resp", rsp_resp, 2'b01);
        check_eq("w2_aw_beats", aw_beats - aw0, 1);
        check_eq("w2_w_beats", w_beats - w0, 1);
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Read with 5-cycle RVALID delay and SLVERR
        issue(1'b0, 32'h20, '0, '0);
        arready = 1;
        step();
        cmd_valid = 0;
        check_eq("r1_arvalid", arvalid, 1);
        check_eq("r1_araddr", araddr, 32'h20);
        check_eq("r1_rready_early", rready, 0);
        step();
        arready = 0;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("r1_arvalid_low%0d", i), arvalid, 0);
            check_eq($sformatf("r1_rready%0d", i), rready, 1);
            check_eq($sformatf("r1_rsp_wait%0d", i), rsp_valid, 0);
            step();
        end
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        step();
        rvalid = 0; rdata = '0;
        check_eq("r1_rsp_valid", rsp_valid, 1);
        check_eq("r1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check_eq("r1_rsp_resp", rsp_resp, 2'b10);
        check_eq("r1_rsp_write", rsp_write, 0);
        check_eq("r1_rready_off", rready, 0);

        // RSP stall with a pending command
        issue(1'b0, 32'h30, '0, '0);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("st_cmd_ready%0d", i), cmd_ready, 0);
            check_eq($sformatf("st_rsp_valid%0d", i), rsp_valid, 1);
            check_eq($sformatf("st_rdata%0d", i), rsp_rdata, 32'hDEAD_BEEF);
            check_eq($sformatf("st_axi_idle%0d", i), {awvalid, wvalid, arvalid, bready, rready}, 0);
            step();
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        check_eq("st_rsp_done", rsp_valid, 0);
        check_eq("st_cmd_ready_next", cmd_ready, 1);
        arready = 1;
        step();
        cmd_valid = 0;
        check_eq("st_arvalid", arvalid, 1);
        check_eq("st_araddr", araddr, 32'h30);
        check_eq("st_cmd_ready_busy", cmd_ready, 0);
        step();
        arready = 0;
        check_eq("rr_rready", rready, 1);

        // Reset during RD_DATA
        #2 rst_n = 1'b0;
        #1;
        check_eq("rr_arvalid", arvalid, 0);
        check_eq("rr_rready_async", rready, 0);
        check_eq("rr_rsp_valid", rsp_valid, 0);
        check_eq("rr_cmd_ready_in_rst", cmd_ready, 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check_eq("rr_cmd_ready", cmd_ready, 1);
        check_eq("rr_rready_idle", rready, 0);
        check_eq("rr_rsp_idle", rsp_valid, 0);

        // Watchdog: BVALID withheld 20 cycles, limit 8
        issue(1'b1, 32'h80, 32'h0BAD_F00D, 4'hF);
        awready = 1; wready = 1;
        step();
        cmd_valid = 0;
        check_eq("wd_timeout_c1", timeout, 0);
        step();
        awready = 0; wready = 0;
        for (int k = 2; k <= 21; k++) begin
            check_eq($sformatf("wd_bready_c%0d", k), bready, 1);
            check_eq($sformatf("wd_timeout_c%0d", k), timeout, (k >= 9) ? 1'b1 : 1'b0);
            step();
        end
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0;
        check_eq("wd_rsp_valid", rsp_valid, 1);
        check_eq("wd_rsp_resp", rsp_resp, 2'b00);
        check_eq("wd_timeout_rsp", timeout, 1);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        check_eq("wd_timeout_clear", timeout, 0);
        check_eq("wd_cmd_ready", cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_cmd.md
Name: axi_lite_master_cmd

Overview:
- Parametrised AXI4-Lite master driven by a simple command/response stream.
- Accepts one command (read or write) at a time and runs the full AXI4-Lite handshake sequence. Write AW and W are issued concurrently and complete independently.
- Returns read data and response code on a response stream, and flags slow slaves with a watchdog.
- Sits between local control logic (register sequencers, DMA setup) and an AXI interconnect slave port.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: address width, 12..64.
- C_M_AXI_DATA_WIDTH, 32: data width, 32 or 64. Strobe width is C_M_AXI_DATA_WIDTH/8.
- C_TIMEOUT_CYCLES, 256: watchdog limit in cycles. 0 disables the watchdog.
- C_M_AXI_PROT, 3'b000: constant driven on AWPROT and ARPROT.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- CMD_VALID  in  1  command valid
- CMD_READY  out  1  command accepted when VALID&READY
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_W  byte address
- CMD_WDATA  in  DATA_W  write data
- CMD_WSTRB  in  DATA_W/8  write strobes
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response accepted
- RSP_WRITE  out  1  response belongs to a write
- RSP_RDATA  out  DATA_W  read data; 0 for writes
- RSP_RESP  out  2  BRESP or RRESP
- TIMEOUT  out  1  watchdog expired on current transaction
- M_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite master signals: AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY

Behaviour:
Reset (async assert, sync deassert internally):
- All VALID/READY outputs, RSP_*, TIMEOUT and the address/data registers are 0.
- State is IDLE.

State machine:
- IDLE
  - CMD_READY=1.
  - On CMD_VALID, register addr/data/strb/write. Go to WR_REQ if write, else RD_REQ.
- WR_REQ
  - AWVALID and WVALID both assert the cycle after acceptance.
  - Each drops the cycle after its own handshake. Done flags aw_done/w_done track which have completed.
  - When both are done (same or different cycles), go to WR_RESP.
- WR_RESP
  - BREADY=1. On BVALID, capture BRESP and go to RSP.
- RD_REQ
  - ARVALID=1. On ARREADY, go to RD_DATA.
- RD_DATA
  - RREADY=1. On RVALID, capture RDATA and RRESP and go to RSP.
- RSP
  - RSP_VALID=1 with fields held stable. On RSP_READY, go to IDLE.
  - Back-to-back minimum: the next CMD is accepted the cycle after the RSP handshake.

Handshake rules:
- VALID is never deasserted before its handshake completes.
- Address, data and strobes are stable while VALID is high.
- Signals are never combinationally dependent on AXI READY inputs.
- BREADY/RREADY are asserted only in their wait states.

Latency:
- Zero-wait slave: write is CMD accept → AW/W at +1 → B at +2 → RSP_VALID at +3. Read is identical.

Watchdog:
- A counter clears on CMD accept and increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
- At C_TIMEOUT_CYCLES it saturates and TIMEOUT=1.
- The transaction is not aborted; it stays AXI-legal.
- TIMEOUT clears on the RSP handshake.
- With C_TIMEOUT_CYCLES=0, TIMEOUT is tied to 0.

Boundaries:
- CMD_VALID outside IDLE is ignored (CMD_READY=0).
- RSP_READY held low stalls indefinitely.
- BVALID/RVALID arriving the same cycle as the last AW/W handshake cannot be captured; BREADY is not yet high.
- Reset mid-transaction drops all VALIDs immediately. Recovering the interconnect is the system's responsibility.

Decomposition:
- Package axi_lite_pkg:
  - RESP codes: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - State encoding localparams.
  - Default PROT.
- Sub-module axi_lite_wdog: a saturating counter with clear, enable and expired outputs, reusable by the slave-side blocks.

Test Plan:
- Write addr 0x10, data 0xA5A5_5A5A, strb 0xF, zero-wait slave → AW/W at +1, BRESP OKAY, RSP_VALID at +3 with RSP_WRITE=1 and RSP_RESP=00.
- Write where WREADY lags AWREADY by 3 cycles → AWVALID drops after its handshake, WVALID is held stable 3 cycles, exactly one AW and one W beat.
- Read addr 0x20, slave returns 0xDEAD_BEEF with RRESP=SLVERR after 5-cycle RVALID delay → RSP_RDATA=0xDEADBEEF, RSP_RESP=10.
- RSP_READY held low 10 cycles with a new CMD_VALID pending → CMD_READY=0 throughout, no AXI activity. Command accepted the cycle after the RSP handshake.
- C_TIMEOUT_CYCLES=8, slave withholds BVALID 20 cycles → TIMEOUT=1 from the 8th wait cycle. BREADY is still high, response completes normally, TIMEOUT clears on RSP handshake.
- Assert reset during RD_DATA → ARVALID/RREADY/RSP_VALID go to 0 asynchronously, state IDLE, CMD_READY=1 after release.
